// File: rtl/de_stage_reg_cmp_pkg.sv
// de_stage_reg_cmp_pkg
// Shared definitions for the Decode-to-Execute boundary block:
//   - default bus widths (DATA_W / REG_W / CTRL_W)
//   - bit positions inside the packed control vector
//     {memtoreg, memwrite, alusrc, regdst, regwrite, alucontrol[2:0]}
//   - the all-zero bubble control word inserted on a flush
package de_stage_reg_cmp_pkg;

  localparam int unsigned DE_DATA_W = 32;
  localparam int unsigned DE_REG_W  = 5;
  localparam int unsigned DE_CTRL_W = 8;

  localparam int unsigned CTRL_MEMTOREG   = 7;
  localparam int unsigned CTRL_MEMWRITE   = 6;
  localparam int unsigned CTRL_ALUSRC     = 5;
  localparam int unsigned CTRL_REGDST     = 4;
  localparam int unsigned CTRL_REGWRITE   = 3;
  localparam int unsigned CTRL_ALUCTL_MSB = 2;
  localparam int unsigned CTRL_ALUCTL_LSB = 0;

  // Bubble: no regwrite, no memwrite, nothing observable downstream.
  localparam logic [DE_CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/de_stage_reg_cmp_floprc_w.sv
// de_stage_reg_cmp_floprc_w
// WIDTH-bit pipeline register with asynchronous active-high reset,
// synchronous clear and load enable. Priority: reset > clear > enable.
// Ports:
//   i_clk  - rising-edge clock
//   i_rst  - asynchronous active-high reset, forces o_q to 0
//   i_clr  - synchronous clear, loads 0 on the next edge
//   i_en   - load enable; when low (and not cleared) the register holds
//   i_d    - data in
//   o_q    - registered data out
module de_stage_reg_cmp_floprc_w #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/de_stage_reg_cmp.sv
// de_stage_reg_cmp
// Decode-to-Execute boundary of the 5-stage MIPS32 pipeline.
//   - Combinational branch comparator on Decode operands, each side
//     optionally replaced by the Memory-stage ALU result (forwarding).
//   - Flush-able D->E pipeline registers for operands, immediate, register
//     numbers and control vector. A flush zeroes every field (bubble).
// Optional build macro: DE_STAGE_STALL_EN adds input en_d; when low and no
// flush is pending, all Execute registers hold.
// Ports:
//   clk, reset              - clock, async active-high reset
//   flush_e                 - sync clear of all Execute registers
//   srca_d, srcb_d          - register-file read data (rs / rt)
//   signimm_d               - sign-extended immediate
//   rs_d, rt_d, rd_d        - register numbers
//   ctrl_d                  - packed control vector
//   aluout_m                - Memory-stage ALU result (forwarding source)
//   fwd_a_d, fwd_b_d        - use aluout_m for compare operand A / B
//   en_d                    - (DE_STAGE_STALL_EN only) register load enable
//   equal_d                 - combinational compare result
//   srca_e .. ctrl_e        - registered Execute-stage copies
module de_stage_reg_cmp
  import de_stage_reg_cmp_pkg::*;
#(
  parameter int unsigned DATA_W = DE_DATA_W,
  parameter int unsigned REG_W  = DE_REG_W,
  parameter int unsigned CTRL_W = DE_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_e,
`ifdef DE_STAGE_STALL_EN
  input  logic              en_d,
`endif
  input  logic [DATA_W-1:0] srca_d,
  input  logic [DATA_W-1:0] srcb_d,
  input  logic [DATA_W-1:0] signimm_d,
  input  logic [REG_W-1:0]  rs_d,
  input  logic [REG_W-1:0]  rt_d,
  input  logic [REG_W-1:0]  rd_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [DATA_W-1:0] aluout_m,
  input  logic              fwd_a_d,
  input  logic              fwd_b_d,
  output logic              equal_d,
  output logic [DATA_W-1:0] srca_e,
  output logic [DATA_W-1:0] srcb_e,
  output logic [DATA_W-1:0] signimm_e,
  output logic [REG_W-1:0]  rs_e,
  output logic [REG_W-1:0]  rt_e,
  output logic [REG_W-1:0]  rd_e,
  output logic [CTRL_W-1:0] ctrl_e
);

  // Branch comparator: independent of reset/flush, no state.
  logic [DATA_W-1:0] w_cmp_a;
  logic [DATA_W-1:0] w_cmp_b;

  assign w_cmp_a = fwd_a_d ? aluout_m : srca_d;
  assign w_cmp_b = fwd_b_d ? aluout_m : srcb_d;
  assign equal_d = (w_cmp_a == w_cmp_b);

  logic w_en;
`ifdef DE_STAGE_STALL_EN
  assign w_en = en_d;
`else
  assign w_en = 1'b1;
`endif

  // Execute registers capture the unforwarded operands; Execute-stage
  // forwarding is resolved downstream.
  de_stage_reg_cmp_floprc_w #(.WIDTH(DATA_W)) u_srca (
    .i_clk(clk), .i_rst(reset), .i_clr(flush_e), .i_en(w_en),
    .i_d(srca_d), .o_q(srca_e)
  );

  de_stage_reg_cmp_floprc_w #(.WIDTH(DATA_W)) u_srcb (
    .i_clk(clk), .i_rst(reset), .i_clr(flush_e), .i_en(w_en),
    .i_d(srcb_d), .o_q(srcb_e)
  );

  de_stage_reg_cmp_floprc_w #(.WIDTH(DATA_W)) u_signimm (
    .i_clk(clk), .i_rst(reset), .i_clr(flush_e), .i_en(w_en),
    .i_d(signimm_d), .o_q(signimm_e)
  );

  de_stage_reg_cmp_floprc_w #(.WIDTH(REG_W)) u_rs (
    .i_clk(clk), .i_rst(reset), .i_clr(flush_e), .i_en(w_en),
    .i_d(rs_d), .o_q(rs_e)
  );

  de_stage_reg_cmp_floprc_w #(.WIDTH(REG_W)) u_rt (
    .i_clk(clk), .i_rst(reset), .i_clr(flush_e), .i_en(w_en),
    .i_d(rt_d), .o_q(rt_e)
  );

  de_stage_reg_cmp_floprc_w #(.WIDTH(REG_W)) u_rd (
    .i_clk(clk), .i_rst(reset), .i_clr(flush_e), .i_en(w_en),
    .i_d(rd_d), .o_q(rd_e)
  );

  de_stage_reg_cmp_floprc_w #(.WIDTH(CTRL_W)) u_ctrl (
    .i_clk(clk), .i_rst(reset), .i_clr(flush_e), .i_en(w_en),
    .i_d(ctrl_d), .o_q(ctrl_e)
  );

endmodule

// File: tb/tb_de_stage_reg_cmp.sv
module tb_de_stage_reg_cmp;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_e;
  logic [31:0] srca_d, srcb_d, signimm_d, aluout_m;
  logic [4:0]  rs_d, rt_d, rd_d;
  logic [7:0]  ctrl_d;
  logic        fwd_a_d, fwd_b_d;
  logic        equal_d;
  logic [31:0] srca_e, srcb_e, signimm_e;
  logic [4:0]  rs_e, rt_e, rd_e;
  logic [7:0]  ctrl_e;
`ifdef DE_STAGE_STALL_EN
  logic        en_d;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  de_stage_reg_cmp dut (
    .clk       (clk),
    .reset     (reset),
    .flush_e   (flush_e),
`ifdef DE_STAGE_STALL_EN
    .en_d      (en_d),
`endif
    .srca_d    (srca_d),
    .srcb_d    (srcb_d),
    .signimm_d (signimm_d),
    .rs_d      (rs_d),
    .rt_d      (rt_d),
    .rd_d      (rd_d),
    .ctrl_d    (ctrl_d),
    .aluout_m  (aluout_m),
    .fwd_a_d   (fwd_a_d),
    .fwd_b_d   (fwd_b_d),
    .equal_d   (equal_d),
    .srca_e    (srca_e),
    .srcb_e    (srcb_e),
    .signimm_e (signimm_e),
    .rs_e      (rs_e),
    .rt_e      (rt_e),
    .rd_e      (rd_e),
    .ctrl_e    (ctrl_e)
  );

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [7:0] ctrl);
    srca_d = a; srcb_d = b; signimm_d = imm;
    rs_d = rs; rt_d = rt; rd_d = rd; ctrl_d = ctrl;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush_e = 1'b0; fwd_a_d = 1'b0; fwd_b_d = 1'b0; aluout_m = '0;
`ifdef DE_STAGE_STALL_EN
    en_d = 1'b1;
`endif
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h1F, 5'h1F, 5'h1F, 8'hFF);
    tick(); tick();
    n_total++;
    if ({srca_e, srcb_e, signimm_e} !== 96'h0) begin
      $display("FAIL reset_data: got %h %h %h, expected all 0", srca_e, srcb_e, signimm_e);
    end else n_pass++;
    n_total++;
    if ({rs_e, rt_e, rd_e, ctrl_e} !== 23'h0) begin
      $display("FAIL reset_regs_ctrl: got %h %h %h %h, expected all 0", rs_e, rt_e, rd_e, ctrl_e);
    end else n_pass++;
    n_total++;
    if (equal_d !== 1'b1) begin
      $display("FAIL reset_equal: got %b, expected 1", equal_d);
    end else n_pass++;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    reset = 1'b0;
    tick();
    n_total++;
    if (srca_e !== 32'hFFFF_FFFF || ctrl_e !== 8'hFF || rd_e !== 5'h1F) begin
      $display("FAIL ones_load: got %h %h %h, expected ffffffff ff 1f", srca_e, ctrl_e, rd_e);
    end else n_pass++;
    // Mid-cycle reset: outputs must clear with no clock edge.
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_total++;
    if ({srca_e, srcb_e, signimm_e, rs_e, rt_e, rd_e, ctrl_e} !== 119'h0) begin
      $display("FAIL async_reset: got %h %h %h %h %h %h %h, expected all 0",
               srca_e, srcb_e, signimm_e, rs_e, rt_e, rd_e, ctrl_e);
    end else n_pass++;
    srcb_d = 32'h0;
    #1;
    n_total++;
    if (equal_d !== 1'b0) begin
      $display("FAIL equal_in_reset: got %b, expected 0", equal_d);
    end else n_pass++;
    tick();
    n_total++;
    if (srca_e !== 32'h0 || ctrl_e !== 8'h0) begin
      $display("FAIL reset_held: got %h %h, expected 0 0", srca_e, ctrl_e);
    end else n_pass++;
  endtask

  task automatic test_capture();
    @(negedge clk);
    reset = 1'b0;
    drive(32'h1234_5678, 32'hCAFE_F00D, 32'hFFFF_FF80, 5'd5, 5'd17, 5'd31, 8'hA5);
    #1;
    n_total++;
    if (srca_e !== 32'h0 || rs_e !== 5'd0 || ctrl_e !== 8'h0) begin
      $display("FAIL capture_early: got %h %h %h, expected 0 0 0", srca_e, rs_e, ctrl_e);
    end else n_pass++;
    tick();
    n_total++;
    if (srca_e !== 32'h1234_5678 || srcb_e !== 32'hCAFE_F00D || signimm_e !== 32'hFFFF_FF80) begin
      $display("FAIL capture_data: got %h %h %h, expected 12345678 cafef00d ffffff80",
               srca_e, srcb_e, signimm_e);
    end else n_pass++;
    n_total++;
    if (rs_e !== 5'd5 || rt_e !== 5'd17 || rd_e !== 5'd31 || ctrl_e !== 8'hA5) begin
      $display("FAIL capture_regs: got %0d %0d %0d %h, expected 5 17 31 a5",
               rs_e, rt_e, rd_e, ctrl_e);
    end else n_pass++;
  endtask

  task automatic test_flush();
    @(negedge clk);
    flush_e = 1'b1;
    drive(32'h0BAD_0001, 32'h0BAD_0002, 32'h0000_0003, 5'd1, 5'd2, 5'd3, 8'h5A);
    tick();
    n_total++;
    if ({srca_e, srcb_e, signimm_e, rs_e, rt_e, rd_e, ctrl_e} !== 119'h0) begin
      $display("FAIL flush_bubble: got %h %h %h %h %h %h %h, expected all 0",
               srca_e, srcb_e, signimm_e, rs_e, rt_e, rd_e, ctrl_e);
    end else n_pass++;
    @(negedge clk);
    flush_e = 1'b0;
    tick();
    n_total++;
    if (srca_e !== 32'h0BAD_0001 || signimm_e !== 32'h3 || rt_e !== 5'd2 || ctrl_e !== 8'h5A) begin
      $display("FAIL flush_recover: got %h %h %0d %h, expected 0bad0001 3 2 5a",
               srca_e, signimm_e, rt_e, ctrl_e);
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [4];
    logic [7:0]  vc [4];
    va[0] = 32'h0000_0001; va[1] = 32'h8000_0000; va[2] = 32'hDEAD_BEEF; va[3] = 32'h0;
    vc[0] = 8'h08;         vc[1] = 8'hC0;         vc[2] = 8'h37;         vc[3] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(va[i], ~va[i], va[i] ^ 32'h5555_5555, 5'(i), 5'(i + 10), 5'(i + 20), vc[i]);
      tick();
      n_total++;
      if (srca_e !== va[i] || srcb_e !== ~va[i] || rd_e !== 5'(i + 20) || ctrl_e !== vc[i]) begin
        $display("FAIL b2b_%0d: got %h %h %0d %h, expected %h %h %0d %h", i,
                 srca_e, srcb_e, rd_e, ctrl_e, va[i], ~va[i], i + 20, vc[i]);
      end else n_pass++;
    end
  endtask

  task automatic test_compare();
    fwd_a_d = 1'b0; fwd_b_d = 1'b0;
    srca_d = 32'hFFFF_0000; srcb_d = 32'hFFFF_0000; #1;
    n_total++;
    if (equal_d !== 1'b1) $display("FAIL cmp_equal: got %b, expected 1", equal_d);
    else n_pass++;
    srcb_d = 32'hFFFF_0001; #1;
    n_total++;
    if (equal_d !== 1'b0) $display("FAIL cmp_lsb: got %b, expected 0", equal_d);
    else n_pass++;
    srcb_d = 32'h7FFF_0000; #1;
    n_total++;
    if (equal_d !== 1'b0) $display("FAIL cmp_msb: got %b, expected 0", equal_d);
    else n_pass++;
  endtask

  task automatic test_forward();
    @(negedge clk);
    srca_d = 32'd3; srcb_d = 32'd9; aluout_m = 32'd9; fwd_a_d = 1'b1; fwd_b_d = 1'b0; #1;
    n_total++;
    if (equal_d !== 1'b1) $display("FAIL fwd_a: got %b, expected 1", equal_d);
    else n_pass++;
    // Forwarding must not leak into the Execute register.
    tick();
    n_total++;
    if (srca_e !== 32'd3) $display("FAIL fwd_unforwarded_e: got %h, expected 3", srca_e);
    else n_pass++;
    @(negedge clk);
    fwd_b_d = 1'b1; srca_d = 32'd0; #1;
    n_total++;
    if (equal_d !== 1'b1) $display("FAIL fwd_both: got %b, expected 1", equal_d);
    else n_pass++;
    fwd_a_d = 1'b0; #1;
    n_total++;
    if (equal_d !== 1'b0) $display("FAIL fwd_b_only: got %b, expected 0", equal_d);
    else n_pass++;
    fwd_b_d = 1'b0; #1;
    n_total++;
    if (equal_d !== 1'b0) $display("FAIL fwd_none: got %b, expected 0", equal_d);
    else n_pass++;
  endtask

`ifdef DE_STAGE_STALL_EN
  task automatic test_stall();
    @(negedge clk);
    drive(32'h1111_2222, 32'h3333_4444, 32'h5, 5'd6, 5'd7, 5'd8, 8'h99);
    tick();
    @(negedge clk);
    en_d = 1'b0;
    drive(32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hC, 5'd9, 5'd10, 5'd11, 8'h11);
    tick();
    n_total++;
    if (srca_e !== 32'h1111_2222 || rs_e !== 5'd6 || ctrl_e !== 8'h99) begin
      $display("FAIL stall_hold: got %h %0d %h, expected 11112222 6 99", srca_e, rs_e, ctrl_e);
    end else n_pass++;
    @(negedge clk);
    flush_e = 1'b1;
    tick();
    n_total++;
    if (srca_e !== 32'h0 || rs_e !== 5'd0 || ctrl_e !== 8'h0) begin
      $display("FAIL stall_flush: got %h %0d %h, expected 0 0 0", srca_e, rs_e, ctrl_e);
    end else n_pass++;
    @(negedge clk);
    flush_e = 1'b0; en_d = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_async_reset();
    test_capture();
    test_flush();
    test_back_to_back();
    test_compare();
    test_forward();
`ifdef DE_STAGE_STALL_EN
    test_stall();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/de_stage_reg_cmp.md
Name: de_stage_reg_cmp

Overview:
- Decode-to-Execute boundary block for the 5-stage pipelined MIPS32 core.
- Contains a combinational 32-bit equality comparator on Decode-stage operands, with a Memory-stage forwarding select, that drives branch resolution (equal_d).
- Contains a bank of flush-able pipeline registers that capture Decode operands, immediate, register numbers and control bits into the Execute stage.
- A flush inserts a bubble: every registered field is zeroed.

Parameters:
- DATA_W, 32, width of operand, immediate and forwarded-result buses.
- REG_W, 5, width of register-number fields.
- CTRL_W, 8, width of the packed control vector ({memtoreg, memwrite, alusrc, regdst, regwrite, alucontrol[2:0]}).

Ports:
- clk  in  1  single pipeline clock; rising-edge active.
- reset  in  1  asynchronous, active-high reset.
- flush_e  in  1  synchronous clear of all Execute-stage registers.
- srca_d  in  DATA_W  register-file read port 1 (rs).
- srcb_d  in  DATA_W  register-file read port 2 (rt).
- signimm_d  in  DATA_W  sign-extended immediate.
- rs_d, rt_d, rd_d  in  REG_W each  register numbers.
- ctrl_d  in  CTRL_W  decoded control vector.
- aluout_m  in  DATA_W  Memory-stage ALU result (forwarding source).
- fwd_a_d, fwd_b_d  in  1 each  select aluout_m instead of srca_d / srcb_d for the compare.
- equal_d  out  1  combinational: compare operand A == compare operand B.
- srca_e, srcb_e, signimm_e  out  DATA_W each  registered operands.
- rs_e, rt_e, rd_e  out  REG_W each  registered register numbers.
- ctrl_e  out  CTRL_W  registered control vector.

Behaviour:
- Compare path (purely combinational, no state):
  - cmp_a = fwd_a_d ? aluout_m : srca_d; cmp_b = fwd_b_d ? aluout_m : srcb_d.
  - equal_d = 1 iff all DATA_W bits of cmp_a and cmp_b match. Bitwise, not signed; no masking.
  - With both forwards set, equal_d = 1.
- Register path: one register per output, all sharing clk/reset/flush_e.
  - reset high, at any time including mid-cycle: all registered outputs go to 0 immediately. This overrides flush_e and the clock. While reset is held, outputs stay 0.
  - Rising clk, reset low, flush_e = 1: all registered outputs load 0 (bubble; ctrl_e = 0 means no regwrite and no memwrite).
  - Rising clk, reset low, flush_e = 0: each output loads its _d input.
  - Latency is exactly one cycle from _d input to _e output.
- Registered srca_e/srcb_e capture the unforwarded srca_d/srcb_d. Forwarding into Execute is handled downstream.
- Priority: reset > flush_e > load.
- equal_d is unaffected by reset and flush_e.
- reset release: the first rising edge after release applies normal flush/load rules.

Optional Feature:
- Macro DE_STAGE_STALL_EN.
- When defined: add input en_d (1 bit). Priority becomes reset > flush_e > (en_d ? load : hold). When en_d = 0 and flush_e = 0, every register holds its value.
- When undefined: no en_d port; registers load every non-flushed edge.

Decomposition:
- Shared package: DATA_W/REG_W/CTRL_W defaults, control-vector bit-index constants (CTRL_MEMTOREG = 7 … CTRL_ALUCTL_LSB = 0), and the zero bubble constant.
- Sub-module floprc_w: parameterized WIDTH register with async reset, sync clear and optional enable. Instantiate it once per field.
- The comparator and the two muxes stay inline.

Test Plan:
- Async reset: load all ones, raise reset between clock edges -> all _e outputs 0 before the next edge; equal_d still tracks its inputs.
- Normal capture: srca_d = 0x12345678, rs_d = 5, ctrl_d = 0xA5, flush_e = 0 -> after one edge srca_e = 0x12345678, rs_e = 5, ctrl_e = 0xA5; no change before the edge.
- Flush: registers hold non-zero values, flush_e = 1 with non-zero _d inputs -> after the edge every _e output = 0. Next edge with flush_e = 0 captures the _d inputs.
- Compare: srca_d = srcb_d = 0xFFFF0000 -> equal_d = 1. Then srcb_d = 0xFFFF0001 -> equal_d = 0. Then srcb_d = 0x7FFF0000 -> equal_d = 0 (MSB difference).
- Forwarding: srca_d = 3, srcb_d = 9, aluout_m = 9, fwd_a_d = 1 -> equal_d = 1. Set fwd_b_d = 1, srca_d = 0 -> equal_d = 1. Clear both -> equal_d = 0.
- With DE_STAGE_STALL_EN: en_d = 0, flush_e = 0, new inputs -> outputs unchanged. en_d = 0, flush_e = 1 -> outputs 0.
